// File: rtl/lsu_mmio.sv
// lsu_mmio -- load/store unit for the single-cycle RV32I core.
//
// Decodes a 16-bit byte address into a 2 KiB data memory (0x0000-0x07FF)
// and a memory-mapped I/O window at 0x7000-0x781F.
// Stores are written on the rising clock edge. Loads are combinational and
// apply RISC-V sign or zero extension.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous reset, ACTIVE-HIGH (the suffix is historical);
//                  clears the I/O output registers but not DMEM
//   addr[15:0]     byte address: word index addr[15:2], lane addr[1:0]
//   w_data[31:0]   store data, already lane-aligned to the addressed word
//   wr_en          store enable
//   bmask[3:0]     store byte-lane enables
//   ld_sel[2:0]    load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU,
//                  anything else LW
//   r_data[31:0]   load result
//   io_ledr/ledg   red/green LEDs (17 and 8 implemented bits)
//   io_hex0..7     7-segment segment lines
//   io_lcd         LCD control/data (bit 31 and bits 10:0 implemented)
//   io_sw, io_btn  switch and button inputs, readable at 0x7800 and 0x7810
module lsu_mmio (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [31:0] w_data,
   input  logic        wr_en,
   input  logic [3:0]  bmask,
   input  logic [2:0]  ld_sel,
   output logic [31:0] r_data,
   output logic [31:0] io_ledr,
   output logic [31:0] io_ledg,
   output logic [6:0]  io_hex0,
   output logic [6:0]  io_hex1,
   output logic [6:0]  io_hex2,
   output logic [6:0]  io_hex3,
   output logic [6:0]  io_hex4,
   output logic [6:0]  io_hex5,
   output logic [6:0]  io_hex6,
   output logic [6:0]  io_hex7,
   output logic [31:0] io_lcd,
   input  logic [31:0] io_sw,
   input  logic [31:0] io_btn
);

   // Storage
   logic [31:0] dmem [512];
   logic [16:0] ledr;
   logic [7:0]  ledg;
   logic [6:0]  hex [8];
   logic        lcd_on;
   logic [10:0] lcd_ctl;

   // Address decode
   logic [11:0] page;
   logic [8:0]  word_idx;
   logic        sel_dmem, sel_ledr, sel_ledg, sel_hex, sel_lcd, sel_sw, sel_btn;
   logic [31:0] wmask;
   logic [31:0] hex_lo, hex_hi, raw;

   assign page     = addr[15:4];
   assign word_idx = addr[10:2];
   assign sel_dmem = (addr[15:11] == 5'd0);
   assign sel_ledr = (page == 12'h700);
   assign sel_ledg = (page == 12'h701);
   assign sel_hex  = (page == 12'h702);
   assign sel_lcd  = (page == 12'h703);
   assign sel_sw   = (page == 12'h780);
   assign sel_btn  = (page == 12'h781);

   // Byte-lane enables expanded to a bit mask.
   always_comb begin
      wmask = '0;
      for (int k = 0; k < 4; k++) begin
         wmask[8*k +: 8] = {8{bmask[k]}};
      end
   end

   // DMEM is not reset; its contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (wr_en && sel_dmem) begin
         dmem[word_idx] <= (dmem[word_idx] & ~wmask) | (w_data & wmask);
      end
   end

   // I/O output registers. Reset held during an edge overrides a store.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ledr    <= '0;
         ledg    <= '0;
         lcd_on  <= 1'b0;
         lcd_ctl <= '0;
         for (int k = 0; k < 8; k++) begin
            hex[k] <= '0;
         end
      end else if (wr_en) begin
         if (sel_ledr) begin
            ledr <= (ledr & ~wmask[16:0]) | (w_data[16:0] & wmask[16:0]);
         end
         if (sel_ledg) begin
            ledg <= (ledg & ~wmask[7:0]) | (w_data[7:0] & wmask[7:0]);
         end
         if (sel_lcd) begin
            lcd_ctl <= (lcd_ctl & ~wmask[10:0]) | (w_data[10:0] & wmask[10:0]);
            if (bmask[3]) begin
               lcd_on <= w_data[31];
            end
         end
         // addr[2] picks HEX0-3 or HEX4-7; bit 7 of each byte is dropped.
         if (sel_hex) begin
            for (int k = 0; k < 4; k++) begin
               if (bmask[k]) begin
                  hex[{addr[2], k[1:0]}] <= w_data[8*k +: 7];
               end
            end
         end
      end
   end

   assign io_ledr = {15'd0, ledr};
   assign io_ledg = {24'd0, ledg};
   assign io_lcd  = {lcd_on, 20'd0, lcd_ctl};
   assign io_hex0 = hex[0];
   assign io_hex1 = hex[1];
   assign io_hex2 = hex[2];
   assign io_hex3 = hex[3];
   assign io_hex4 = hex[4];
   assign io_hex5 = hex[5];
   assign io_hex6 = hex[6];
   assign io_hex7 = hex[7];

   assign hex_lo = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
   assign hex_hi = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};

   // Raw word selection; unmapped addresses read as zero.
   always_comb begin
      raw = '0;
      if (sel_dmem)      raw = dmem[word_idx];
      else if (sel_ledr) raw = io_ledr;
      else if (sel_ledg) raw = io_ledg;
      else if (sel_hex)  raw = addr[2] ? hex_hi : hex_lo;
      else if (sel_lcd)  raw = io_lcd;
      else if (sel_sw)   raw = io_sw;
      else if (sel_btn)  raw = io_btn;
   end

   // Extract the addressed byte/halfword and extend it.
   function automatic logic [31:0] format_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  sel);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sel)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   assign r_data = format_load(raw, addr[1:0], ld_sel);

endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio -- directed self-checking bench for lsu_mmio.
// Each task drives one scenario and compares against hand-computed values.
module tb_lsu_mmio;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [31:0] w_data;
   logic        wr_en;
   logic [3:0]  bmask;
   logic [2:0]  ld_sel;
   logic [31:0] r_data;
   logic [31:0] io_ledr, io_ledg, io_lcd, io_sw, io_btn;
   logic [6:0]  io_hex0, io_hex1, io_hex2, io_hex3;
   logic [6:0]  io_hex4, io_hex5, io_hex6, io_hex7;
   logic [6:0]  hx [8];

   int checks;
   int failures;
   logic [31:0] shadow [512];

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                          LBU = 3'b100, LHU = 3'b101;

   lsu_mmio dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .w_data(w_data),
      .wr_en(wr_en), .bmask(bmask), .ld_sel(ld_sel), .r_data(r_data),
      .io_ledr(io_ledr), .io_ledg(io_ledg),
      .io_hex0(io_hex0), .io_hex1(io_hex1), .io_hex2(io_hex2), .io_hex3(io_hex3),
      .io_hex4(io_hex4), .io_hex5(io_hex5), .io_hex6(io_hex6), .io_hex7(io_hex7),
      .io_lcd(io_lcd), .io_sw(io_sw), .io_btn(io_btn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      hx[0] = io_hex0; hx[1] = io_hex1; hx[2] = io_hex2; hx[3] = io_hex3;
      hx[4] = io_hex4; hx[5] = io_hex5; hx[6] = io_hex6; hx[7] = io_hex7;
   end

   task automatic do_store(input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] m);
      @(negedge clk);
      addr = a; w_data = d; bmask = m; wr_en = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0; bmask = 4'b0000;
   endtask

   task automatic do_load(input logic [15:0] a, input logic [2:0] s,
                          output logic [31:0] d);
      @(negedge clk);
      addr = a; ld_sel = s;
      #1;
      d = r_data;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (io_ledr !== 32'd0) begin failures++; $display("FAIL reset_ledr got=%h want=%h", io_ledr, 32'd0); end
      checks++;
      if (io_ledg !== 32'd0) begin failures++; $display("FAIL reset_ledg got=%h want=%h", io_ledg, 32'd0); end
      checks++;
      if (io_lcd !== 32'd0) begin failures++; $display("FAIL reset_lcd got=%h want=%h", io_lcd, 32'd0); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (hx[k] !== 7'd0) begin failures++; $display("FAIL reset_hex%0d got=%h want=%h", k, hx[k], 7'd0); end
      end
      @(negedge clk);
      rst_n = 1'b0;
      do_load(16'h7000, LW, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL reset_read_ledr got=%h want=%h", d, 32'd0); end
   endtask

   task automatic test_hex();
      logic [31:0] d;
      do_store(16'h7020, 32'hFFFF_FFFF, 4'b1111);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (hx[k] !== 7'h7F) begin failures++; $display("FAIL hex%0d got=%h want=%h", k, hx[k], 7'h7F); end
      end
      for (int k = 4; k < 8; k++) begin
         checks++;
         if (hx[k] !== 7'h00) begin failures++; $display("FAIL hex%0d_untouched got=%h want=%h", k, hx[k], 7'h00); end
      end
      do_load(16'h7020, LW, d);
      checks++;
      if (d !== 32'h7F7F_7F7F) begin failures++; $display("FAIL hex_lo_read got=%h want=%h", d, 32'h7F7F_7F7F); end
      do_store(16'h7024, 32'h8181_8181, 4'b1111);
      for (int k = 4; k < 8; k++) begin
         checks++;
         if (hx[k] !== 7'h01) begin failures++; $display("FAIL hex%0d got=%h want=%h", k, hx[k], 7'h01); end
      end
      do_load(16'h7024, LW, d);
      checks++;
      if (d !== 32'h0101_0101) begin failures++; $display("FAIL hex_hi_read got=%h want=%h", d, 32'h0101_0101); end
      // Partial-lane HEX store: only lane 2 (HEX2) changes.
      do_store(16'h7020, 32'h0055_0000, 4'b0100);
      do_load(16'h7020, LW, d);
      checks++;
      if (d !== 32'h7F55_7F7F) begin failures++; $display("FAIL hex_lane_read got=%h want=%h", d, 32'h7F55_7F7F); end
   endtask

   task automatic test_leds_lcd();
      logic [31:0] d;
      do_store(16'h7000, 32'hFFFF_FFFF, 4'b1111);
      do_store(16'h7010, 32'hFFFF_FFFF, 4'b1111);
      do_store(16'h7030, 32'hFFFF_FFFF, 4'b1111);
      checks++;
      if (io_ledr !== 32'h0001_FFFF) begin failures++; $display("FAIL ledr got=%h want=%h", io_ledr, 32'h0001_FFFF); end
      checks++;
      if (io_ledg !== 32'h0000_00FF) begin failures++; $display("FAIL ledg got=%h want=%h", io_ledg, 32'h0000_00FF); end
      checks++;
      if (io_lcd !== 32'h8000_07FF) begin failures++; $display("FAIL lcd got=%h want=%h", io_lcd, 32'h8000_07FF); end
      do_load(16'h7000, LW, d);
      checks++;
      if (d !== 32'h0001_FFFF) begin failures++; $display("FAIL ledr_read got=%h want=%h", d, 32'h0001_FFFF); end
      do_load(16'h7010, LW, d);
      checks++;
      if (d !== 32'h0000_00FF) begin failures++; $display("FAIL ledg_read got=%h want=%h", d, 32'h0000_00FF); end
      do_load(16'h7030, LW, d);
      checks++;
      if (d !== 32'h8000_07FF) begin failures++; $display("FAIL lcd_read got=%h want=%h", d, 32'h8000_07FF); end
      // Clearing only the top byte of the LCD drops bit 31 and keeps the rest.
      do_store(16'h7030, 32'h0000_0000, 4'b1000);
      checks++;
      if (io_lcd !== 32'h0000_07FF) begin failures++; $display("FAIL lcd_lane got=%h want=%h", io_lcd, 32'h0000_07FF); end
   endtask

   task automatic test_dmem_sweep();
      logic [31:0] d;
      int idx [6];
      idx = '{0, 1, 255, 256, 510, 511};
      for (int i = 0; i < 512; i++) begin
         shadow[i] = $urandom;
         do_store(16'(i * 4), shadow[i], 4'b1111);
         do_load(16'(i * 4), LW, d);
         checks++;
         if (d !== shadow[i]) begin failures++; $display("FAIL dmem_word%0d got=%h want=%h", i, d, shadow[i]); end
      end
      for (int j = 0; j < 6; j++) begin
         do_load(16'(idx[j] * 4), LW, d);
         checks++;
         if (d !== shadow[idx[j]]) begin failures++; $display("FAIL dmem_alias%0d got=%h want=%h", idx[j], d, shadow[idx[j]]); end
      end
   endtask

   task automatic test_subword();
      logic [31:0] d;
      do_store(16'h0010, 32'h8081_F2F3, 4'b1111);
      do_load(16'h0011, LB, d);
      checks++;
      if (d !== 32'hFFFF_FFF2) begin failures++; $display("FAIL lb got=%h want=%h", d, 32'hFFFF_FFF2); end
      do_load(16'h0011, LBU, d);
      checks++;
      if (d !== 32'h0000_00F2) begin failures++; $display("FAIL lbu got=%h want=%h", d, 32'h0000_00F2); end
      do_load(16'h0013, LB, d);
      checks++;
      if (d !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_b3 got=%h want=%h", d, 32'hFFFF_FF80); end
      do_load(16'h0012, LH, d);
      checks++;
      if (d !== 32'hFFFF_8081) begin failures++; $display("FAIL lh got=%h want=%h", d, 32'hFFFF_8081); end
      do_load(16'h0012, LHU, d);
      checks++;
      if (d !== 32'h0000_8081) begin failures++; $display("FAIL lhu got=%h want=%h", d, 32'h0000_8081); end
      do_load(16'h0011, LHU, d);
      checks++;
      if (d !== 32'h0000_F2F3) begin failures++; $display("FAIL lhu_lo got=%h want=%h", d, 32'h0000_F2F3); end
      do_load(16'h0013, 3'b111, d);
      checks++;
      if (d !== 32'h8081_F2F3) begin failures++; $display("FAIL ldsel_default got=%h want=%h", d, 32'h8081_F2F3); end
      do_store(16'h0010, 32'h0000_00AA, 4'b0001);
      do_load(16'h0010, LW, d);
      checks++;
      if (d !== 32'h8081_F2AA) begin failures++; $display("FAIL sb got=%h want=%h", d, 32'h8081_F2AA); end
      do_store(16'h0010, 32'h1111_1111, 4'b0000);
      do_load(16'h0010, LW, d);
      checks++;
      if (d !== 32'h8081_F2AA) begin failures++; $display("FAIL bmask0 got=%h want=%h", d, 32'h8081_F2AA); end
   endtask

   task automatic test_inputs_unmapped();
      logic [31:0] d;
      io_sw  = 32'h1234_5678;
      io_btn = 32'h0000_000F;
      do_load(16'h7800, LW, d);
      checks++;
      if (d !== 32'h1234_5678) begin failures++; $display("FAIL sw got=%h want=%h", d, 32'h1234_5678); end
      do_load(16'h7810, LW, d);
      checks++;
      if (d !== 32'h0000_000F) begin failures++; $display("FAIL btn got=%h want=%h", d, 32'h0000_000F); end
      do_store(16'h7800, 32'hDEAD_BEEF, 4'b1111);
      do_load(16'h7800, LW, d);
      checks++;
      if (d !== 32'h1234_5678) begin failures++; $display("FAIL sw_after_store got=%h want=%h", d, 32'h1234_5678); end
      do_load(16'h4000, LW, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h want=%h", d, 32'd0); end
      // Address 0x4000 shares DMEM index bits with 0x0000; it must not write there.
      do_store(16'h4000, 32'hCAFE_F00D, 4'b1111);
      do_load(16'h0000, LW, d);
      checks++;
      if (d !== shadow[0]) begin failures++; $display("FAIL unmapped_store got=%h want=%h", d, shadow[0]); end
   endtask

   task automatic test_same_cycle();
      do_store(16'h0020, 32'hA5A5_0001, 4'b1111);
      @(negedge clk);
      addr = 16'h0020; ld_sel = LW; w_data = 32'h5A5A_0002; bmask = 4'b1111; wr_en = 1'b1;
      #1;
      checks++;
      if (r_data !== 32'hA5A5_0001) begin failures++; $display("FAIL same_cycle_old got=%h want=%h", r_data, 32'hA5A5_0001); end
      @(posedge clk);
      #1;
      wr_en = 1'b0; bmask = 4'b0000;
      checks++;
      if (r_data !== 32'h5A5A_0002) begin failures++; $display("FAIL same_cycle_new got=%h want=%h", r_data, 32'h5A5A_0002); end
   endtask

   task automatic test_reset_wins();
      do_store(16'h7010, 32'h0000_0033, 4'b0001);
      checks++;
      if (io_ledg !== 32'h0000_0033) begin failures++; $display("FAIL ledg_pre got=%h want=%h", io_ledg, 32'h0000_0033); end
      @(negedge clk);
      addr = 16'h7010; w_data = 32'h0000_00C3; bmask = 4'b1111; wr_en = 1'b1; rst_n = 1'b1;
      #1;
      checks++;
      if (io_ledg !== 32'd0) begin failures++; $display("FAIL async_reset got=%h want=%h", io_ledg, 32'd0); end
      @(posedge clk);
      #1;
      checks++;
      if (io_ledg !== 32'd0) begin failures++; $display("FAIL reset_wins got=%h want=%h", io_ledg, 32'd0); end
      checks++;
      if (io_hex4 !== 7'd0) begin failures++; $display("FAIL reset_hex4 got=%h want=%h", io_hex4, 7'd0); end
      wr_en = 1'b0; bmask = 4'b0000;
      @(negedge clk);
      rst_n = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b1; addr = '0; w_data = '0; wr_en = 1'b0; bmask = '0;
      ld_sel = LW; io_sw = '0; io_btn = '0;
      test_reset();
      test_hex();
      test_leds_lcd();
      test_dmem_sweep();
      test_subword();
      test_inputs_unmapped();
      test_same_cycle();
      test_reset_wins();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
